regfile_scoreboard: RTL and testbench

Parametrised register file for the pipelined core. It replaces the fixed 16-entry 4-to-16 write decode with an N-entry one-hot write decoder. It adds two read ports with write-to-read bypass, an optional hardwired-zero register, and a per-register pending (scoreboard) bit for hazard detection. It sits between decode (reads, issue) and writeback (writes).

---
 rtl/regfile_pkg.sv | 18 +
 rtl/regfile_scoreboard_onehot_wr_decoder.sv | 34 +++
 rtl/regfile_scoreboard.sv | 107 ++++++++++
 tb/tb_regfile_scoreboard.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Brief    : Shared defaults and ZERO_REG encoding for the register file.
// Revision : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   // Default register-file geometry
   localparam int DEFAULT_NUM_REGS = 16;
   localparam int DEFAULT_DATA_W   = 16;

   // ZERO_REG parameter encoding
   localparam int ZERO_REG_OFF = 0;
   localparam int ZERO_REG_ON  = 1;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_onehot_wr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : onehot_wr_decoder
// Brief    : N-entry one-hot decoder with optional R0 suppression. Used for
//            both the writeback write strobes and the scoreboard set strobes.
// Revision : 1.0 - initial release
// ============================================================================
module onehot_wr_decoder
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEFAULT_NUM_REGS,
   parameter  int ZERO_REG = ZERO_REG_OFF,
   localparam int ID_W     = $clog2(NUM_REGS)
) (
   input  logic [ID_W-1:0]     i_id,
   input  logic                i_en,
   output logic [NUM_REGS-1:0] o_onehot
);

   // One bit per register; R0 is masked when it is the hardwired zero
   always_comb begin
      o_onehot = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (i_en && (i_id == ID_W'(i))) begin
            o_onehot[i] = 1'b1;
         end
      end
      if (ZERO_REG == ZERO_REG_ON) begin
         o_onehot[0] = 1'b0;
      end
   end

endmodule : onehot_wr_decoder
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Parametrised register file with two bypassed read ports,
//            optional hardwired-zero R0 and a per-register pending bit.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter  int NUM_REGS = DEFAULT_NUM_REGS,
   parameter  int DATA_W   = DEFAULT_DATA_W,
   parameter  int ZERO_REG = ZERO_REG_OFF,
   localparam int ID_W     = $clog2(NUM_REGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ID_W-1:0]     wr_id,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [ID_W-1:0]     rd_id_a,
   input  logic [ID_W-1:0]     rd_id_b,
   output logic [DATA_W-1:0]   rd_data_a,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic                rd_pend_a,
   output logic                rd_pend_b,
   input  logic                iss_en,
   input  logic [ID_W-1:0]     iss_id,
   output logic [NUM_REGS-1:0] wordline,
   output logic [NUM_REGS-1:0] pend_vec
);

   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_pend;
   logic [NUM_REGS-1:0] r_wordline;
   logic [NUM_REGS-1:0] w_dec;
   logic [NUM_REGS-1:0] w_set;
   logic                w_zero_a;
   logic                w_zero_b;

   // Writeback strobes; also serve as the scoreboard clear strobes
   onehot_wr_decoder #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_wr_dec (
      .i_id     (wr_id),
      .i_en     (wr_en),
      .o_onehot (w_dec)
   );

   // Issue strobes; R0 suppression keeps the zero register never pending
   onehot_wr_decoder #(
      .NUM_REGS (NUM_REGS),
      .ZERO_REG (ZERO_REG)
   ) u_iss_dec (
      .i_id     (iss_id),
      .i_en     (iss_en),
      .o_onehot (w_set)
   );

   // Storage, trace wordline and scoreboard; set beats clear (younger producer)
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_pend     <= '0;
         r_wordline <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_dec[i]) begin
               r_regs[i] <= wr_data;
            end
         end
         r_pend     <= (r_pend & ~w_dec) | w_set;
         r_wordline <= w_dec;
      end
   end

   // Read ports: zero register first, then same-cycle bypass, then storage
   always_comb begin
      w_zero_a  = (ZERO_REG == ZERO_REG_ON) && (rd_id_a == '0);
      w_zero_b  = (ZERO_REG == ZERO_REG_ON) && (rd_id_b == '0);
      rd_data_a = r_regs[rd_id_a];
      rd_data_b = r_regs[rd_id_b];
      if (w_dec[rd_id_a]) begin
         rd_data_a = wr_data;
      end
      if (w_dec[rd_id_b]) begin
         rd_data_b = wr_data;
      end
      if (w_zero_a) begin
         rd_data_a = '0;
      end
      if (w_zero_b) begin
         rd_data_b = '0;
      end
      // A register being written this cycle is no longer waiting on a producer
      rd_pend_a = r_pend[rd_id_a] & ~w_dec[rd_id_a];
      rd_pend_b = r_pend[rd_id_b] & ~w_dec[rd_id_b];
   end

   assign wordline = r_wordline;
   assign pend_vec = r_pend;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Directed, table-driven bench for regfile_scoreboard. One instance
//            with ZERO_REG=0 and one with ZERO_REG=1 share the stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [3:0]  wr_id;
   logic [15:0] wr_data;
   logic [3:0]  rd_id_a, rd_id_b;
   logic        iss_en;
   logic [3:0]  iss_id;

   logic [15:0] rd_data_a, rd_data_b, wordline, pend_vec;
   logic        rd_pend_a, rd_pend_b;
   logic [15:0] z_rd_data_a, z_rd_data_b, z_wordline, z_pend_vec;
   logic        z_rd_pend_a, z_rd_pend_b;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_id;
      logic [15:0] wr_data;
      logic [3:0]  rd_a;
      logic [3:0]  rd_b;
      logic        iss_en;
      logic [3:0]  iss_id;
      logic [15:0] ea;
      logic [15:0] eb;
      logic        epa;
      logic        epb;
      logic [15:0] epend;
      logic [15:0] ewl;
   } vec_t;

   vec_t tbl [11];

   always #5 clk = ~clk;

   regfile_scoreboard #(.NUM_REGS(16), .DATA_W(16), .ZERO_REG(0)) u_dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
      .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
      .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
      .rd_pend_a(rd_pend_a), .rd_pend_b(rd_pend_b),
      .iss_en(iss_en), .iss_id(iss_id),
      .wordline(wordline), .pend_vec(pend_vec)
   );

   regfile_scoreboard #(.NUM_REGS(16), .DATA_W(16), .ZERO_REG(1)) u_dz (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_id(wr_id), .wr_data(wr_data),
      .rd_id_a(rd_id_a), .rd_id_b(rd_id_b),
      .rd_data_a(z_rd_data_a), .rd_data_b(z_rd_data_b),
      .rd_pend_a(z_rd_pend_a), .rd_pend_b(z_rd_pend_b),
      .iss_en(iss_en), .iss_id(iss_id),
      .wordline(z_wordline), .pend_vec(z_pend_vec)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic we, input logic [3:0] wid, input logic [15:0] wd,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic ie, input logic [3:0] iid);
      wr_en   = we;
      wr_id   = wid;
      wr_data = wd;
      rd_id_a = ra;
      rd_id_b = rb;
      iss_en  = ie;
      iss_id  = iid;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all_zero_reads(input string tag);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), 1'b0, 4'd0);
         #1;
         check($sformatf("%s_rda_r%0d", tag, i), {16'h0, rd_data_a}, 32'h0);
         check($sformatf("%s_rdb_r%0d", tag, 15 - i), {16'h0, rd_data_b}, 32'h0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //                 we   id     data     ra     rb    ie   iid     ea        eb      pa    pb    pend      wl
      tbl[0]  = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd0, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0020};
      tbl[1]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 1'b0, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 16'h0000, 16'h0000};
      tbl[2]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd3, 1'b1, 4'd3, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 16'h0008, 16'h0000};
      tbl[3]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd3, 1'b0, 4'd0, 16'hBEEF, 16'h0000, 1'b0, 1'b1, 16'h0008, 16'h0000};
      tbl[4]  = '{1'b1, 4'd3, 16'h00AA, 4'd3, 4'd3, 1'b0, 4'd0, 16'h00AA, 16'h00AA, 1'b0, 1'b0, 16'h0000, 16'h0008};
      tbl[5]  = '{1'b1, 4'd7, 16'h1111, 4'd7, 4'd3, 1'b1, 4'd7, 16'h1111, 16'h00AA, 1'b0, 1'b0, 16'h0080, 16'h0080};
      tbl[6]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 4'd0, 16'h1111, 16'h1111, 1'b1, 1'b1, 16'h0080, 16'h0000};
      tbl[7]  = '{1'b1, 4'd7, 16'h2222, 4'd7, 4'd3, 1'b0, 4'd0, 16'h2222, 16'h00AA, 1'b0, 1'b0, 16'h0000, 16'h0080};
      tbl[8]  = '{1'b1, 4'd15,16'hFFFF, 4'd15,4'd1, 1'b1, 4'd1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0002, 16'h8000};
      tbl[9]  = '{1'b1, 4'd2, 16'hABCD, 4'd1, 4'd2, 1'b1, 4'd1, 16'h0000, 16'hABCD, 1'b1, 1'b0, 16'h0002, 16'h0004};
      tbl[10] = '{1'b1, 4'd0, 16'h1234, 4'd0, 4'd1, 1'b0, 4'd0, 16'h1234, 16'h0000, 1'b0, 1'b1, 16'h0002, 16'h0001};

      // Reset and check the cleared state
      rst = 1'b1;
      drive(1'b1, 4'd6, 16'hDEAD, 4'd0, 4'd0, 1'b1, 4'd6);
      tick();
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      #1;
      check("reset_pend_vec", {16'h0, pend_vec}, 32'h0);
      check("reset_wordline", {16'h0, wordline}, 32'h0);
      idle_all_zero_reads("reset");

      // Table-driven vectors on the ZERO_REG=0 instance
      for (int v = 0; v < 11; v++) begin
         drive(tbl[v].wr_en, tbl[v].wr_id, tbl[v].wr_data, tbl[v].rd_a, tbl[v].rd_b,
               tbl[v].iss_en, tbl[v].iss_id);
         @(negedge clk);
         check($sformatf("v%0d_rd_data_a", v), {16'h0, rd_data_a}, {16'h0, tbl[v].ea});
         check($sformatf("v%0d_rd_data_b", v), {16'h0, rd_data_b}, {16'h0, tbl[v].eb});
         check($sformatf("v%0d_rd_pend_a", v), {31'h0, rd_pend_a}, {31'h0, tbl[v].epa});
         check($sformatf("v%0d_rd_pend_b", v), {31'h0, rd_pend_b}, {31'h0, tbl[v].epb});
         tick();
         check($sformatf("v%0d_pend_vec", v), {16'h0, pend_vec}, {16'h0, tbl[v].epend});
         check($sformatf("v%0d_wordline", v), {16'h0, wordline}, {16'h0, tbl[v].ewl});
      end

      // Hardwired zero register: write and issue R0 on both instances
      rst = 1'b1;
      drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      tick();
      rst = 1'b0;
      drive(1'b1, 4'd0, 16'h1234, 4'd0, 4'd0, 1'b1, 4'd0);
      @(negedge clk);
      check("zr_bypass_rd_a", {16'h0, z_rd_data_a}, 32'h0);
      check("zr_pend_a", {31'h0, z_rd_pend_a}, 32'h0);
      check("nz_bypass_rd_a", {16'h0, rd_data_a}, 32'h1234);
      tick();
      drive(1'b0, 4'd0, 16'h0, 4'd0, 4'd0, 1'b0, 4'd0);
      #1;
      check("zr_pend_vec", {16'h0, z_pend_vec}, 32'h0);
      check("zr_wordline", {16'h0, z_wordline}, 32'h0);
      check("zr_rd_a_after", {16'h0, z_rd_data_a}, 32'h0);
      check("nz_pend_vec", {16'h0, pend_vec}, 32'h0001);
      check("nz_wordline", {16'h0, wordline}, 32'h0001);
      check("nz_rd_a_after", {16'h0, rd_data_a}, 32'h1234);

      // Mid-operation reset: pending bits and writes are discarded
      drive(1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b1, 4'd1);
      tick();
      drive(1'b0, 4'd0, 16'h0, 4'd1, 4'd2, 1'b1, 4'd2);
      tick();
      drive(1'b1, 4'd9, 16'h5555, 4'd9, 4'd2, 1'b0, 4'd0);
      tick();
      check("pre_rst_pend_vec", {16'h0, pend_vec}, 32'h0007);
      check("pre_rst_z_pend_vec", {16'h0, z_pend_vec}, 32'h0006);
      check("pre_rst_rd_a_r9", {16'h0, rd_data_a}, 32'h5555);
      rst = 1'b1;
      drive(1'b1, 4'd4, 16'h7777, 4'd4, 4'd9, 1'b1, 4'd5);
      tick();
      rst = 1'b0;
      drive(1'b0, 4'd0, 16'h0, 4'd4, 4'd9, 1'b0, 4'd0);
      #1;
      check("rst_pend_vec", {16'h0, pend_vec}, 32'h0);
      check("rst_wordline", {16'h0, wordline}, 32'h0);
      check("rst_z_pend_vec", {16'h0, z_pend_vec}, 32'h0);
      check("rst_rd_a_r4", {16'h0, rd_data_a}, 32'h0);
      check("rst_rd_b_r9", {16'h0, rd_data_b}, 32'h0);
      idle_all_zero_reads("midrst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_regfile_scoreboard
`default_nettype wire
